scale_arbiter: RTL

- Shares one downstream fixed-point scale unit between NUM_REQ requesters, e.g. per-lane accumulator drains.
- Holds one 32-bit scale register per requester and arbitrates round-robin.
- Drives the scale unit's scale/data/valid inputs and reloads the scale only when the granted requester changes or its scale has been rewritten.
- Tracks in-flight words with a tag FIFO so each result returns to the requester that issued it.

---
 rtl/scale_arbiter_if.sv | 22 ++
 rtl/scale_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/scale_arbiter_if.sv
// Scale-unit bus of scale_arbiter: scale/data issue towards the unit, result back.
// Signal suffixes are named from the arbiter's side (master).
interface scale_arbiter_if #(
  parameter int DATA_W = 32
) ();
  logic [DATA_W-1:0] su_scale_o;
  logic              su_scale_valid_o;
  logic              su_data_valid_o;
  logic [DATA_W-1:0] su_data_o;
  logic              su_valid_i;
  logic [DATA_W-1:0] su_data_i;

  modport master (
    output su_scale_o, su_scale_valid_o, su_data_valid_o, su_data_o,
    input  su_valid_i, su_data_i
  );

  modport slave (
    input  su_scale_o, su_scale_valid_o, su_data_valid_o, su_data_o,
    output su_valid_i, su_data_i
  );
endinterface

// File: rtl/scale_arbiter.sv
// Round-robin sharing of one fixed-point scale unit between NUM_REQ requesters,
// with lazy scale reload and a tag FIFO routing results back. Stats: SCALE_ARB_STATS_EN.
module scale_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 32,
  parameter int TAG_DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       cfg_valid_i,
  input  logic [$clog2(NUM_REQ)-1:0] cfg_req_i,
  input  logic [DATA_W-1:0]          cfg_scale_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  scale_arbiter_if.master            su,
  output logic [NUM_REQ-1:0]         rsp_valid_o,
  output logic [DATA_W-1:0]          rsp_data_o,
  output logic                       err_o
`ifdef SCALE_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]      stat_issue_o,
  output logic [31:0]                stat_reload_o
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0]  scale_q [NUM_REQ];
  logic [NUM_REQ-1:0] scale_set_q;
  logic [IDX_W-1:0]   loaded_id_q, loaded_id_d;
  logic               loaded_ok_q, loaded_ok_d;
  logic [IDX_W-1:0]   rr_ptr_q;

  logic [IDX_W-1:0]   tag_mem_q [TAG_DEPTH];
  logic [PTR_W-1:0]   tag_wr_q, tag_rd_q;
  logic [CNT_W-1:0]   tag_cnt_q, tag_cnt_d;

  logic [DATA_W-1:0]  su_scale_q, su_data_q;
  logic               su_scale_valid_q, su_data_valid_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [DATA_W-1:0]  rsp_data_q;
  logic               err_q;

  logic [NUM_REQ-1:0] eligible, grant_oh;
  logic [IDX_W-1:0]   gnt_idx, cand;
  logic               hs, need_reload, pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0]  gnt_data;

  assign eligible   = req_valid_i & scale_set_q;
  assign fifo_full  = (tag_cnt_q == CNT_W'(TAG_DEPTH));
  assign fifo_empty = (tag_cnt_q == '0);

  always_comb begin
    grant_oh = '0;
    gnt_idx  = '0;
    hs       = 1'b0;
    cand     = '0;
    if (!fifo_full) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        cand = rr_ptr_q + IDX_W'(i);
        if (!hs && eligible[cand]) begin
          hs      = 1'b1;
          gnt_idx = cand;
        end
      end
    end
    if (hs) grant_oh[gnt_idx] = 1'b1;
  end

  assign req_ready_o = grant_oh;
  assign gnt_data    = req_data_i[gnt_idx*DATA_W +: DATA_W];
  assign need_reload = (gnt_idx != loaded_id_q) || !loaded_ok_q;
  assign pop         = su.su_valid_i && !fifo_empty;

  always_comb begin
    loaded_id_d = loaded_id_q;
    loaded_ok_d = loaded_ok_q;
    if (hs && need_reload) begin
      loaded_id_d = gnt_idx;
      loaded_ok_d = 1'b1;
    end
    // Compared against the post-issue id: a rewrite racing the issue of that
    // requester must still force a reload on its following word.
    if (cfg_valid_i && (cfg_req_i == loaded_id_d)) loaded_ok_d = 1'b0;
  end

  always_comb begin
    tag_cnt_d = tag_cnt_q;
    if (hs && !pop)      tag_cnt_d = tag_cnt_q + CNT_W'(1);
    else if (!hs && pop) tag_cnt_d = tag_cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned r = 0; r < NUM_REQ; r++) scale_q[r] <= '0;
      for (int unsigned t = 0; t < TAG_DEPTH; t++) tag_mem_q[t] <= '0;
      scale_set_q      <= '0;
      loaded_id_q      <= '0;
      loaded_ok_q      <= 1'b0;
      rr_ptr_q         <= '0;
      tag_wr_q         <= '0;
      tag_rd_q         <= '0;
      tag_cnt_q        <= '0;
      su_scale_q       <= '0;
      su_data_q        <= '0;
      su_scale_valid_q <= 1'b0;
      su_data_valid_q  <= 1'b0;
      rsp_valid_q      <= '0;
      rsp_data_q       <= '0;
      err_q            <= 1'b0;
    end else begin
      if (cfg_valid_i) begin
        scale_q[cfg_req_i]     <= cfg_scale_i;
        scale_set_q[cfg_req_i] <= 1'b1;
      end
      loaded_id_q <= loaded_id_d;
      loaded_ok_q <= loaded_ok_d;
      tag_cnt_q   <= tag_cnt_d;

      su_data_valid_q  <= hs;
      su_scale_valid_q <= hs && need_reload;
      if (hs) begin
        su_data_q           <= gnt_data;
        rr_ptr_q            <= gnt_idx + IDX_W'(1);
        tag_mem_q[tag_wr_q] <= gnt_idx;
        tag_wr_q            <= tag_wr_q + PTR_W'(1);
        if (need_reload) su_scale_q <= scale_q[gnt_idx];
      end

      rsp_valid_q <= '0;
      if (pop) begin
        rsp_valid_q <= NUM_REQ'(1) << tag_mem_q[tag_rd_q];
        rsp_data_q  <= su.su_data_i;
        tag_rd_q    <= tag_rd_q + PTR_W'(1);
      end
      if (su.su_valid_i && fifo_empty) err_q <= 1'b1;
    end
  end

  assign su.su_scale_o       = su_scale_q;
  assign su.su_scale_valid_o = su_scale_valid_q;
  assign su.su_data_valid_o  = su_data_valid_q;
  assign su.su_data_o        = su_data_q;
  assign rsp_valid_o         = rsp_valid_q;
  assign rsp_data_o          = rsp_data_q;
  assign err_o               = err_q;

`ifdef SCALE_ARB_STATS_EN
  logic [31:0] stat_issue_q [NUM_REQ];
  logic [31:0] stat_reload_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned r = 0; r < NUM_REQ; r++) stat_issue_q[r] <= '0;
      stat_reload_q <= '0;
    end else if (hs) begin
      stat_issue_q[gnt_idx] <= stat_issue_q[gnt_idx] + 32'd1;
      if (need_reload) stat_reload_q <= stat_reload_q + 32'd1;
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
    assign stat_issue_o[gi*32 +: 32] = stat_issue_q[gi];
  end
  assign stat_reload_o = stat_reload_q;
`endif

endmodule
